engine_memory_arbiter: RTL and testbench

- Shares one pipelined instruction-memory read port among 2**ENGINE_ID_BITS vectorial engines.
- Each engine exposes a read-request port: it drives addr/valid and receives ready/data plus a broadcast addr/valid for cache snooping.
- The arbiter grants round-robin, tracks in-flight reads through a fixed-latency return pipe, and returns data to the owner.
- On each return it broadcasts the fill address to all engines and completes any other engine waiting on the same address (coalescing).

---
 rtl/engine_memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_engine_memory_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_memory_arbiter.sv
// Round-robin arbiter that shares one pipelined read port among 2**ENGINE_ID_BITS engines and coalesces same-address readers.
// Latency: an uncontended read completes MEM_LATENCY+2 cycles after eng_valid (grant reg, memory, return reg).
// Backpressure: while mem_valid & !mem_ready the issue is held stable and no new grant is made.
module engine_memory_arbiter #(
    parameter int ENGINE_ID_BITS    = 2,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEM_LATENCY       = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [(2**ENGINE_ID_BITS)-1:0]                      eng_valid,
    input  logic [(2**ENGINE_ID_BITS)*MEMORY_ADDR_WIDTH-1:0]    eng_addr,
    output logic [(2**ENGINE_ID_BITS)-1:0]                      eng_ready,
    output logic [MEMORY_WIDTH-1:0]                             eng_data,
    output logic [MEMORY_ADDR_WIDTH-1:0]                        broadcast_addr,
    output logic                                                broadcast_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                        mem_addr,
    output logic                                                mem_valid,
    input  logic                                                mem_ready,
    input  logic [MEMORY_WIDTH-1:0]                             mem_data
);
    localparam int N  = 2**ENGINE_ID_BITS;
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int IW = ENGINE_ID_BITS;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] issue_id;
    logic [IW-1:0] gnt_id;
    logic [IW-1:0] cand;
    logic          gnt_found;
    logic          can_issue;
    logic          accept;
    logic [N-1:0]  inflight;
    logic [N-1:0]  inflight_nxt;
    logic [N-1:0]  coal_hit;
    logic [N-1:0]  elig;
    logic [N-1:0]  ret_onehot;
    logic [AW-1:0] addr_arr [N];

    logic          pipe_vld  [MEM_LATENCY];
    logic [IW-1:0] pipe_id   [MEM_LATENCY];
    logic [AW-1:0] pipe_addr [MEM_LATENCY];

    logic          ret_vld;
    logic [IW-1:0] ret_id;
    logic [AW-1:0] ret_addr;

    assign ret_vld   = pipe_vld[MEM_LATENCY-1];
    assign ret_id    = pipe_id[MEM_LATENCY-1];
    assign ret_addr  = pipe_addr[MEM_LATENCY-1];
    assign can_issue = !mem_valid || mem_ready;
    assign accept    = mem_valid && mem_ready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_arr[i] = eng_addr[i*AW +: AW];
        end
    end

    // Engines already waiting on the returning address ride along and skip arbitration.
    always_comb begin
        coal_hit   = '0;
        elig       = '0;
        ret_onehot = '0;
        for (int i = 0; i < N; i++) begin
            coal_hit[i]   = ret_vld && eng_valid[i] && !inflight[i] && (addr_arr[i] == ret_addr);
            elig[i]       = eng_valid[i] && !inflight[i] && !coal_hit[i];
            ret_onehot[i] = ret_vld && (ret_id == IW'(i));
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = rr_ptr;
        cand      = rr_ptr;
        for (int k = 0; k < N; k++) begin
            cand = rr_ptr + IW'(k);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // Grant and return never target the same engine: a returning engine is still inflight.
    always_comb begin
        inflight_nxt = inflight;
        if (can_issue && gnt_found) begin
            inflight_nxt[gnt_id] = 1'b1;
        end
        if (ret_vld) begin
            inflight_nxt[ret_id] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr          <= '0;
            issue_id        <= '0;
            inflight        <= '0;
            mem_valid       <= 1'b0;
            mem_addr        <= '0;
            eng_ready       <= '0;
            eng_data        <= '0;
            broadcast_addr  <= '0;
            broadcast_valid <= 1'b0;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                pipe_vld[k]  <= 1'b0;
                pipe_id[k]   <= '0;
                pipe_addr[k] <= '0;
            end
        end else begin
            if (can_issue) begin
                mem_valid <= gnt_found;
                if (gnt_found) begin
                    mem_addr <= addr_arr[gnt_id];
                    issue_id <= gnt_id;
                    rr_ptr   <= gnt_id + IW'(1);
                end
            end
            inflight <= inflight_nxt;

            pipe_vld[0]  <= accept;
            pipe_id[0]   <= issue_id;
            pipe_addr[0] <= mem_addr;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_id[k]   <= pipe_id[k-1];
                pipe_addr[k] <= pipe_addr[k-1];
            end

            broadcast_valid <= ret_vld;
            eng_ready       <= ret_onehot | coal_hit;
            if (ret_vld) begin
                eng_data       <= mem_data;
                broadcast_addr <= ret_addr;
            end
        end
    end
endmodule

// File: tb/tb_engine_memory_arbiter.sv
// Randomised bench for engine_memory_arbiter with a transaction-level reference model and directed literal scenarios.
module tb_engine_memory_arbiter;
    localparam int N  = 4;
    localparam int AW = 11;
    localparam int MW = 16;
    localparam int L  = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    eng_valid;
    logic [N*AW-1:0] eng_addr;
    logic [N-1:0]    eng_ready;
    logic [MW-1:0]   eng_data;
    logic [AW-1:0]   broadcast_addr;
    logic            broadcast_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_valid;
    logic            mem_ready;
    logic [MW-1:0]   mem_data;

    engine_memory_arbiter #(
        .ENGINE_ID_BITS(2), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .eng_valid(eng_valid), .eng_addr(eng_addr),
        .eng_ready(eng_ready), .eng_data(eng_data), .broadcast_addr(broadcast_addr),
        .broadcast_valid(broadcast_valid), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int issues_20;

    logic [MW-1:0] mem_arr [2048];
    bit            mq_vld  [64];
    logic [AW-1:0] mq_addr [64];

    bit            eng_v [N];
    logic [AW-1:0] eng_a [N];

    // Reference model: per-engine ownership plus a calendar of pending returns keyed by due cycle.
    bit [N-1:0]    m_infl;
    int            m_rr;
    bit            m_mv;
    logic [AW-1:0] m_maddr;
    int            m_mid;
    bit [N-1:0]    m_ready;
    bit            m_bv;
    logic [MW-1:0] m_data;
    logic [AW-1:0] m_baddr;
    bit            rq_vld  [64];
    int            rq_id   [64];
    logic [AW-1:0] rq_addr [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic model_clear();
        m_infl = '0; m_rr = 0; m_mv = 0; m_maddr = '0; m_mid = 0;
        m_ready = '0; m_bv = 0; m_data = '0; m_baddr = '0;
        for (int i = 0; i < 64; i++) rq_vld[i] = 0;
    endtask

    task automatic model_step();
        int s; bit rv; bit [N-1:0] coal; bit [N-1:0] elig; int g; int e; int d;
        s = cyc % 64; rv = rq_vld[s]; rq_vld[s] = 0;
        coal = '0; elig = '0;
        for (int i = 0; i < N; i++) begin
            if (eng_v[i] && !m_infl[i]) begin
                if (rv && eng_a[i] == rq_addr[s]) coal[i] = 1'b1;
                else elig[i] = 1'b1;
            end
        end
        if (m_mv && mem_ready) begin
            d = (cyc + L) % 64;
            rq_vld[d] = 1; rq_id[d] = m_mid; rq_addr[d] = m_maddr;
        end
        if (!m_mv || mem_ready) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                e = (m_rr + k) % N;
                if (g < 0 && elig[e]) g = e;
            end
            if (g >= 0) begin
                m_mv = 1; m_maddr = eng_a[g]; m_mid = g; m_infl[g] = 1'b1; m_rr = (g + 1) % N;
            end else begin
                m_mv = 0;
            end
        end
        if (rv) begin
            m_ready = coal; m_ready[rq_id[s]] = 1'b1;
            m_bv = 1; m_data = mem_arr[rq_addr[s]]; m_baddr = rq_addr[s];
            m_infl[rq_id[s]] = 1'b0;
        end else begin
            m_ready = '0; m_bv = 0;
        end
    endtask

    // Memory environment: answers each accepted read exactly L edges later, garbage otherwise.
    task automatic drive_mem();
        int s;
        if (mem_valid === 1'b1 && mem_ready) begin
            mq_vld[(cyc + L) % 64]  = 1;
            mq_addr[(cyc + L) % 64] = mem_addr;
            if (mem_addr == 11'h020) issues_20++;
        end
        s = cyc % 64;
        mem_data = mq_vld[s] ? mem_arr[mq_addr[s]] : MW'($urandom);
        mq_vld[s] = 0;
    endtask

    task automatic compare();
        chk("eng_ready", 32'(eng_ready), 32'(m_ready));
        chk("bcast_valid", 32'(broadcast_valid), 32'(m_bv));
        chk("eng_data", 32'(eng_data), 32'(m_data));
        chk("bcast_addr", 32'(broadcast_addr), 32'(m_baddr));
        chk("mem_valid", 32'(mem_valid), 32'(m_mv));
        if (m_mv) chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) begin
            eng_valid[i]           = eng_v[i];
            eng_addr[i*AW +: AW]   = eng_a[i];
        end
        drive_mem();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare();
    endtask

    // Engines drop their request once the completion pulse is seen.
    task automatic dtick();
        tick();
        for (int i = 0; i < N; i++) if (m_ready[i]) eng_v[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) eng_v[i] = 0;
        eng_valid = '0;
        #1;
        chk("rst_eng_ready", 32'(eng_ready), 32'h0);
        chk("rst_eng_data", 32'(eng_data), 32'h0);
        chk("rst_bcast_addr", 32'(broadcast_addr), 32'h0);
        chk("rst_bcast_valid", 32'(broadcast_valid), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        model_clear();
        drive_mem();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b1;
        compare();
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_data = '0; eng_valid = '0; eng_addr = '0;
        issues_20 = 0;
        for (int i = 0; i < 2048; i++) mem_arr[i] = MW'($urandom);
        mem_arr[11'h005] = 16'hBEEF;
        mem_arr[11'h020] = 16'h5A5A;
        for (int i = 0; i < 64; i++) mq_vld[i] = 0;
        for (int i = 0; i < N; i++) begin eng_v[i] = 0; eng_a[i] = '0; end
        model_clear();
        @(negedge clk);
        do_reset();
        dtick();

        // Single request from engine 1
        mem_ready = 1; eng_v[1] = 1; eng_a[1] = 11'h005;
        dtick();
        chk("single_mem_valid", 32'(mem_valid), 32'h1);
        chk("single_mem_addr", 32'(mem_addr), 32'h005);
        dtick();
        chk("single_no_reissue", 32'(mem_valid), 32'h0);
        dtick();
        chk("single_not_yet", 32'(eng_ready), 32'h0);
        dtick();
        chk("single_ready", 32'(eng_ready), 32'h2);
        chk("single_model_ready", 32'(m_ready), 32'h2);
        chk("single_data", 32'(eng_data), 32'hBEEF);
        chk("single_bcast_addr", 32'(broadcast_addr), 32'h005);
        chk("single_bcast_valid", 32'(broadcast_valid), 32'h1);
        repeat (3) dtick();

        // Backpressure on a pending issue
        mem_ready = 0; eng_v[2] = 1; eng_a[2] = 11'h010;
        dtick();
        eng_v[0] = 1; eng_a[0] = 11'h011;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", 32'(mem_valid), 32'h1);
            chk("bp_hold_addr", 32'(mem_addr), 32'h010);
            if (k < 2) dtick();
        end
        mem_ready = 1;
        dtick();
        chk("bp_next_grant", 32'(mem_addr), 32'h011);
        dtick();
        dtick();
        chk("bp_ret_eng2", 32'(eng_ready), 32'h4);
        dtick();
        chk("bp_ret_eng0", 32'(eng_ready), 32'h1);
        repeat (3) dtick();

        // Coalescing on address 0x20
        issues_20 = 0;
        eng_v[0] = 1; eng_a[0] = 11'h020;
        repeat (3) dtick();
        eng_v[2] = 1; eng_a[2] = 11'h020;
        dtick();
        chk("coal_ready", 32'(eng_ready), 32'h5);
        chk("coal_model_ready", 32'(m_ready), 32'h5);
        chk("coal_data", 32'(eng_data), 32'h5A5A);
        repeat (4) dtick();
        chk("coal_one_issue", 32'(issues_20), 32'h1);

        // Re-request by engine 3
        eng_v[3] = 1; eng_a[3] = 11'h030;
        dtick();
        chk("rereq_first", 32'(mem_addr), 32'h030);
        dtick();
        chk("rereq_not_inflight", 32'(mem_valid), 32'h0);
        repeat (2) tick();
        chk("rereq_ready", 32'(eng_ready), 32'h8);
        eng_a[3] = 11'h031;
        tick();
        chk("rereq_regrant_valid", 32'(mem_valid), 32'h1);
        chk("rereq_regrant_addr", 32'(mem_addr), 32'h031);
        eng_v[3] = 0;
        repeat (4) dtick();

        // Reset with reads in flight, then round-robin from engine 0
        for (int i = 0; i < N; i++) begin eng_v[i] = 1; eng_a[i] = AW'(11'h100 + i); end
        repeat (2) dtick();
        do_reset();
        for (int i = 0; i < N; i++) begin eng_v[i] = 1; eng_a[i] = AW'(11'h100 + i); end
        for (int k = 0; k < N; k++) begin
            dtick();
            chk("rr_grant", 32'(mem_addr), 32'(11'h100 + k));
        end
        for (int k = 0; k < N; k++) begin
            chk("rr_return", 32'(eng_ready), 32'(4'(1) << k));
            dtick();
        end
        repeat (3) dtick();

        // Random traffic with a mid-run reset
        for (int t = 0; t < 3000; t++) begin
            if (t == 1500) do_reset();
            for (int i = 0; i < N; i++) begin
                if (!eng_v[i] && ($urandom % 3) == 0) begin
                    eng_v[i] = 1;
                    eng_a[i] = (($urandom % 4) == 0) ? AW'($urandom) : AW'($urandom % 8);
                end
            end
            mem_ready = (($urandom % 4) != 0);
            dtick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
